// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side drain logic.
package fifo_rd_pkg;

    // Default FIFO data width
    localparam int unsigned DATA_W_DEF = 8;

    // Drain controller states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    // Bits needed to index n entries (minimum 1)
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Single-clock circular buffer holding words captured from the FIFO.
module fifo_rd_buf
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W  = clog2(DEPTH),
    localparam int unsigned CNT_BW = clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_BW-1:0] o_count,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_BW-1:0] r_count;
    logic [PTR_W-1:0]  w_wr_ptr_nxt;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;
    logic              w_pop;

    // Pointer wrap handles non-power-of-two depths; pop ignored when empty
    always_comb begin
        w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
        w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
        w_pop        = i_pop && (r_count != '0);
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            unique case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_BW'(1);
                2'b01:   r_count <= r_count - CNT_BW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head word and occupancy outputs
    always_comb begin
        o_head  = r_mem[r_rd_ptr];
        o_count = r_count;
        o_empty = (r_count == '0);
    end

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side consumer of the async FIFO: issues credit-limited reads, buffers
// captured words and presents them on a valid/ready stream.
module fifo_rd_drain
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              i_rd_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_empty,
    input  logic              i_underflow,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_rd_enbl,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    input  logic              i_out_ready,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_word_cnt,
    output logic              o_underflow_err
);

    localparam int unsigned CNT_BW = clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_inflight;
    logic [CNT_W-1:0]  r_word_cnt;
    logic              r_underflow_err;

    logic              w_run;
    logic              w_credit;
    logic [CNT_BW:0]   w_used;
    logic              w_pop;
    logic              w_buf_empty;
    logic [CNT_BW-1:0] w_buf_count;
    logic [DATA_W-1:0] w_head;

    fifo_rd_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .i_clk       (i_rd_clk),
        .i_rst       (i_rst),
        .i_push      (r_inflight),
        .i_push_data (i_rd_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_buf_count),
        .o_empty     (w_buf_empty)
    );

    // State register
    always_ff @(posedge i_rd_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: DRAIN finishes only once nothing is buffered or in flight
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (i_en) w_state_nxt = StRun;
            StRun:   if (!i_en) w_state_nxt = StDrain;
            StDrain: begin
                if (i_en) begin
                    w_state_nxt = StRun;
                end else if (!r_inflight && w_buf_empty) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_run  = (r_state == StRun);
        o_busy = (r_state != StIdle);
    end

    // Read issue: a word in flight already owns a buffer slot
    always_comb begin
        w_used    = {1'b0, w_buf_count} + (CNT_BW + 1)'(r_inflight);
        w_credit  = (w_used < (CNT_BW + 1)'(BUF_DEPTH));
        o_rd_enbl = w_run && !i_empty && w_credit;
    end

    // Downstream stream; data forced to zero while nothing is held
    always_comb begin
        o_out_valid = !w_buf_empty;
        o_out_data  = w_buf_empty ? '0 : w_head;
        w_pop       = o_out_valid && i_out_ready;
    end

    // Read latency tracking: rd_data is valid the cycle after rd_enbl
    always_ff @(posedge i_rd_clk) begin
        if (i_rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= o_rd_enbl;
        end
    end

    // Saturating word counter (clear wins) and sticky underflow (set wins)
    always_ff @(posedge i_rd_clk) begin
        if (i_rst) begin
            r_word_cnt      <= '0;
            r_underflow_err <= 1'b0;
        end else begin
            if (i_clr) begin
                r_word_cnt <= '0;
            end else if (r_inflight && (r_word_cnt != CNT_MAX)) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            if (i_underflow) begin
                r_underflow_err <= 1'b1;
            end else if (i_clr) begin
                r_underflow_err <= 1'b0;
            end
        end
    end

    // Counter and flag outputs
    always_comb begin
        o_word_cnt      = r_word_cnt;
        o_underflow_err = r_underflow_err;
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Self-checking bench for fifo_rd_drain: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_fifo_rd_drain;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BUF_DEPTH = 4;
    localparam int unsigned CNT_W     = 4;
    localparam int          CNT_SAT   = (1 << CNT_W) - 1;

    logic              rd_clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              clr = 1'b0;
    logic              empty = 1'b1;
    logic              underflow = 1'b0;
    logic [DATA_W-1:0] rd_data = '0;
    logic              rd_enbl;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready = 1'b0;
    logic              busy;
    logic [CNT_W-1:0]  word_cnt;
    logic              underflow_err;

    fifo_rd_drain #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .i_rd_clk        (rd_clk),
        .i_rst           (rst),
        .i_en            (en),
        .i_clr           (clr),
        .i_empty         (empty),
        .i_underflow     (underflow),
        .i_rd_data       (rd_data),
        .o_rd_enbl       (rd_enbl),
        .o_out_valid     (out_valid),
        .o_out_data      (out_data),
        .i_out_ready     (out_ready),
        .o_busy          (busy),
        .o_word_cnt      (word_cnt),
        .o_underflow_err (underflow_err)
    );

    always #5 rd_clk = ~rd_clk;

    int n_chk = 0;
    int n_err = 0;
    int n_rd  = 0;
    int n_hs  = 0;

    // Reference model: upstream FIFO contents, local buffer, in-flight word
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] mbuf[$];
    logic              m_infl = 1'b0;
    logic [DATA_W-1:0] m_infl_word = '0;
    logic              m_run = 1'b0;
    logic              m_busy = 1'b0;
    int                m_cnt = 0;
    logic              m_err = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model
    task automatic tick();
        logic              exp_rd;
        logic              drained;
        logic [DATA_W-1:0] w;
        empty = (fifo_q.size() == 0);
        @(negedge rd_clk);
        exp_rd = m_run && (fifo_q.size() != 0) &&
                 ((mbuf.size() + int'(m_infl)) < int'(BUF_DEPTH));
        check_val("rd_enbl", 32'(rd_enbl), 32'(exp_rd));
        check_val("out_valid", 32'(out_valid), 32'(mbuf.size() != 0));
        if (mbuf.size() != 0) begin
            check_val("out_data", 32'(out_data), 32'(mbuf[0]));
        end
        check_val("busy", 32'(busy), 32'(m_busy));
        check_val("word_cnt", 32'(word_cnt), 32'(m_cnt));
        check_val("underflow_err", 32'(underflow_err), 32'(m_err));
        if (rd_enbl) n_rd++;
        if (out_valid && out_ready) n_hs++;
        @(posedge rd_clk);
        #1;
        w = '0;
        if (exp_rd) begin
            w = fifo_q.pop_front();
            rd_data = w;
        end else begin
            rd_data = DATA_W'($urandom);
        end
        if (rst) begin
            mbuf.delete();
            m_infl = 1'b0;
            m_run  = 1'b0;
            m_busy = 1'b0;
            m_cnt  = 0;
            m_err  = 1'b0;
        end else begin
            drained = (mbuf.size() == 0) && !m_infl;
            if ((mbuf.size() != 0) && out_ready) void'(mbuf.pop_front());
            if (m_infl) mbuf.push_back(m_infl_word);
            if (clr) m_cnt = 0;
            else if (m_infl && (m_cnt < CNT_SAT)) m_cnt = m_cnt + 1;
            if (underflow) m_err = 1'b1;
            else if (clr) m_err = 1'b0;
            m_busy      = en || (m_busy && (m_run || !drained));
            m_run       = en;
            m_infl      = exp_rd;
            m_infl_word = w;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int base_rd;
    int base_hs;
    bit hit;

    initial begin
        // 1: reset, three words streamed back to back
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        check_val("rst_out_data", 32'(out_data), 32'h0);
        check_val("rst_rd_enbl", 32'(rd_enbl), 32'h0);
        fifo_q = '{8'h11, 8'h22, 8'h33};
        en = 1'b1;
        out_ready = 1'b1;
        base_rd = n_rd;
        run(6);
        check_val("t1_reads", 32'(n_rd - base_rd), 32'd3);
        check_val("t1_word_cnt", 32'(word_cnt), 32'd3);
        en = 1'b0;
        run(4);
        check_val("t1_busy_fall", 32'(busy), 32'h0);

        // 2: backpressure limits reads to buffer depth
        for (int i = 0; i < 10; i++) fifo_q.push_back(DATA_W'(8'hA0 + i));
        out_ready = 1'b0;
        en = 1'b1;
        base_rd = n_rd;
        run(10);
        check_val("t2_reads", 32'(n_rd - base_rd), 32'(BUF_DEPTH));
        check_val("t2_head", 32'(out_data), 32'hA0);
        out_ready = 1'b1;
        base_hs = n_hs;
        run(20);
        check_val("t2_delivered", 32'(n_hs - base_hs), 32'd10);
        en = 1'b0;
        run(4);

        // 3: en dropped mid-stream; in-flight word still delivered
        for (int i = 0; i < 6; i++) fifo_q.push_back(DATA_W'(8'hC0 + i));
        en = 1'b1;
        base_rd = n_rd;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (n_rd - base_rd == 1) hit = 1'b1;
        end
        check_val("t3_first_read", 32'(hit), 32'h1);
        en = 1'b0;
        run(8);
        check_val("t3_reads", 32'(n_rd - base_rd), 32'd2);
        check_val("t3_idle", 32'(busy), 32'h0);
        check_val("t3_fifo_left", 32'(fifo_q.size()), 32'd4);
        fifo_q.delete();

        // 4: sticky underflow and clear
        underflow = 1'b1;
        tick();
        underflow = 1'b0;
        run(3);
        check_val("t4_err_hold", 32'(underflow_err), 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_val("t4_err_clr", 32'(underflow_err), 32'h0);
        check_val("t4_cnt_clr", 32'(word_cnt), 32'h0);
        underflow = 1'b1;
        clr = 1'b1;
        tick();
        underflow = 1'b0;
        clr = 1'b0;
        check_val("t4_set_wins", 32'(underflow_err), 32'h1);

        // 5: reset with three buffered and one in flight
        for (int i = 0; i < 8; i++) fifo_q.push_back(DATA_W'(8'h50 + i));
        out_ready = 1'b0;
        en = 1'b1;
        base_rd = n_rd;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (n_rd - base_rd == 4) hit = 1'b1;
        end
        check_val("t5_fill", 32'(hit), 32'h1);
        rst = 1'b1;
        en = 1'b0;
        tick();
        rst = 1'b0;
        check_val("t5_valid", 32'(out_valid), 32'h0);
        check_val("t5_cnt", 32'(word_cnt), 32'h0);
        check_val("t5_busy", 32'(busy), 32'h0);
        run(3);
        fifo_q.delete();

        // 6: word count saturation
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 20; i++) fifo_q.push_back(DATA_W'($urandom));
        out_ready = 1'b1;
        en = 1'b1;
        run(30);
        check_val("t6_sat", 32'(word_cnt), 32'(CNT_SAT));
        en = 1'b0;
        run(5);
        check_val("t6_hold", 32'(word_cnt), 32'(CNT_SAT));

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 39) == 0);
            underflow = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) != 0) fifo_q.push_back(DATA_W'($urandom));
            if ((c % 400) > 350) en = 1'b0;
            tick();
        end
        rst = 1'b0;
        clr = 1'b0;
        underflow = 1'b0;
        en = 1'b0;
        out_ready = 1'b1;
        run(10);
        check_val("final_idle", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
